// File: rtl/bi_shift_stack.sv
// Bidirectional shift-register LIFO stack with occupancy, flags and registered pop data.
// Optional rotate on op=11 is enabled by defining BI_SHIFT_STACK_ROTATE_EN.
module bi_shift_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic [1:0]             op,
  input  logic [WIDTH-1:0]       din,
  input  logic                   flag_clr,
  output logic [WIDTH-1:0]       top,
  output logic [DEPTH*WIDTH-1:0] data_flat,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   pop_valid,
  output logic                   ovf,
  output logic                   unf
);

  localparam logic [CW-1:0] CountMax = CW'(DEPTH);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_set, unf_set;

  assign full  = (count_q == CountMax);
  assign empty = (count_q == '0);
  assign top   = stack_q[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign data_flat[g*WIDTH +: WIDTH] = stack_q[g];
  end

  always_comb begin
    stack_d     = stack_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    if (enb) begin
      case (op)
        2'b01: begin
          for (int unsigned i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
          stack_d[DEPTH-1] = din;
          // When full the bottom entry falls off and count saturates.
          if (full) ovf_set = 1'b1;
          else      count_d = count_q + CW'(1);
        end
        2'b10: begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            pop_data_d  = stack_q[DEPTH-1];
            pop_valid_d = 1'b1;
            for (int unsigned i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
            stack_d[0] = '0;
            count_d    = count_q - CW'(1);
          end
        end
`ifdef BI_SHIFT_STACK_ROTATE_EN
        2'b11: begin
          // Rotates every slot, valid or not; count is untouched.
          for (int unsigned i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
          stack_d[0] = stack_q[DEPTH-1];
        end
`endif
        default: ;
      endcase
    end
    // A set in the same cycle as flag_clr wins.
    ovf_d = (ovf_q & ~flag_clr) | ovf_set;
    unf_d = (unf_q & ~flag_clr) | unf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign count     = count_q;
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule
